// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and default constants for the frequency-sweep sequencer
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_st_t;

    localparam int unsigned BASE_STEP    = 34300;
    localparam int unsigned IDLE_FRE_DEF = BASE_STEP * 3;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - dwell down-counter; expire is high in the last cycle of a dwell
module dwell_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // A load of 0 behaves as 1 so a zero dwell still holds each word one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val == '0) ? W'(1) : load_val;
        end else if (cnt > W'(1)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/fre_sweep_ctrl.sv
// rtl/fre_sweep_ctrl.sv - DDS frequency-word sweep sequencer; SWEEP_LOOP_EN selects continuous sweeping
module fre_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int FRE_W = 32,
    parameter int DWELL_W = 24,
    parameter logic [FRE_W-1:0] IDLE_FRE = FRE_W'(IDLE_FRE_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FRE_W-1:0]   cfg_fre_start,
    input  logic [FRE_W-1:0]   cfg_fre_stop,
    input  logic [FRE_W-1:0]   cfg_fre_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [FRE_W-1:0]   fre_k,
    output logic               fre_upd,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]         state;
    logic [FRE_W-1:0]   sh_stop;
    logic [FRE_W-1:0]   sh_step;
    logic [DWELL_W-1:0] sh_dwell;
`ifdef SWEEP_LOOP_EN
    logic [FRE_W-1:0]   sh_start;
`endif

    logic [FRE_W:0]     nxt;
    logic               cfg_bad;
    logic               launch;
    logic               step_now;
    logic               restart;
    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_val;
    logic               expire;

    always_comb begin
        // One extra bit so a carry out of the word counts as overshooting stop
        nxt      = {1'b0, fre_k} + {1'b0, sh_step};
        cfg_bad  = (cfg_fre_step == '0) || (cfg_fre_start > cfg_fre_stop);
        launch   = (state == S_IDLE) && start && !abort && !cfg_bad;
        step_now = (state == S_RUN) && expire && !abort && (fre_k != sh_stop);
`ifdef SWEEP_LOOP_EN
        restart  = (state == S_DONE) && !abort;
`else
        restart  = 1'b0;
`endif
        tmr_load = launch || step_now || restart;
        tmr_val  = launch ? cfg_dwell : sh_dwell;
    end

    dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fre_k    <= IDLE_FRE;
            fre_upd  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            sh_stop  <= '0;
            sh_step  <= '0;
            sh_dwell <= '0;
`ifdef SWEEP_LOOP_EN
            sh_start <= '0;
`endif
        end else begin
            fre_upd <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (abort) begin
                state   <= S_IDLE;
                fre_k   <= IDLE_FRE;
                fre_upd <= (fre_k != IDLE_FRE);
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            sh_stop  <= cfg_fre_stop;
                            sh_step  <= cfg_fre_step;
                            sh_dwell <= cfg_dwell;
`ifdef SWEEP_LOOP_EN
                            sh_start <= cfg_fre_start;
`endif
                            if (cfg_bad) begin
                                cfg_err <= 1'b1;
                            end else begin
                                fre_k   <= cfg_fre_start;
                                fre_upd <= 1'b1;
                                busy    <= 1'b1;
                                state   <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (expire) begin
                            if (fre_k == sh_stop) begin
                                state <= S_DONE;
                                done  <= 1'b1;
`ifndef SWEEP_LOOP_EN
                                busy  <= 1'b0;
`endif
                            end else if (nxt > {1'b0, sh_stop}) begin
                                fre_k   <= sh_stop;
                                fre_upd <= 1'b1;
                            end else begin
                                fre_k   <= nxt[FRE_W-1:0];
                                fre_upd <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
`ifdef SWEEP_LOOP_EN
                        fre_k   <= sh_start;
                        fre_upd <= 1'b1;
                        state   <= S_RUN;
`else
                        state   <= S_IDLE;
`endif
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fre_sweep_ctrl.sv
// tb/tb_fre_sweep_ctrl.sv - self-checking bench for fre_sweep_ctrl with a schedule-based reference model
module tb_fre_sweep_ctrl;

    localparam logic [31:0] IDLE_V = 32'd102900;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg_fre_start;
    logic [31:0] cfg_fre_stop;
    logic [31:0] cfg_fre_step;
    logic [23:0] cfg_dwell;
    logic [31:0] fre_k;
    logic        fre_upd;
    logic        busy;
    logic        done;
    logic        cfg_err;

    fre_sweep_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_fre_start (cfg_fre_start),
        .cfg_fre_stop  (cfg_fre_stop),
        .cfg_fre_step  (cfg_fre_step),
        .cfg_dwell     (cfg_dwell),
        .fre_k         (fre_k),
        .fre_upd       (fre_upd),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the accepted configuration is expanded into the list of
    // words; outputs then follow from the cycle offset k since launch.
    logic [31:0]       e_fre;
    logic              e_upd, e_busy, e_done, e_err;
    longint unsigned   words[$];
    int                m_d, m_k;
    bit                m_act;

    task automatic model_reset();
        e_fre = IDLE_V; e_upd = 0; e_busy = 0; e_done = 0; e_err = 0;
        m_act = 0; m_k = 0;
    endtask

    task automatic model_eval();
        int n, kk, idx, ph;
        n  = words.size();
        kk = m_k;
`ifdef SWEEP_LOOP_EN
        kk = m_k % (n * m_d + 1);
`endif
        idx = kk / m_d;
        ph  = kk % m_d;
        if (idx < n) begin
            e_fre  = 32'(words[idx]);
            e_upd  = (ph == 0);
            e_busy = 1;
        end else if (kk == n * m_d) begin
            e_fre  = 32'(words[n-1]);
            e_done = 1;
`ifdef SWEEP_LOOP_EN
            e_busy = 1;
`else
            e_busy = 0;
`endif
        end else begin
            m_act  = 0;
            e_busy = 0;
        end
    endtask

    task automatic model_step();
        longint unsigned w, nx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_upd = 0; e_done = 0; e_err = 0;
        if (abort) begin
            e_upd  = (e_fre != IDLE_V);
            e_fre  = IDLE_V;
            e_busy = 0;
            m_act  = 0;
        end else if (m_act) begin
            m_k++;
            model_eval();
        end else if (start) begin
            if (cfg_fre_step == 0 || cfg_fre_start > cfg_fre_stop) begin
                e_err = 1;
            end else begin
                words.delete();
                w = cfg_fre_start;
                words.push_back(w);
                while (w != cfg_fre_stop) begin
                    nx = w + cfg_fre_step;
                    w  = (nx > cfg_fre_stop) ? cfg_fre_stop : nx;
                    words.push_back(w);
                end
                m_d   = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
                m_k   = 0;
                m_act = 1;
                model_eval();
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_fre_k", fre_k, e_fre);
            check("cyc_fre_upd", 32'(fre_upd), 32'(e_upd));
            check("cyc_busy", 32'(busy), 32'(e_busy));
            check("cyc_done", 32'(done), 32'(e_done));
            check("cyc_cfg_err", 32'(cfg_err), 32'(e_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [23:0] d);
        cfg_fre_start = s; cfg_fre_stop = e; cfg_fre_step = st; cfg_dwell = d;
    endtask

    task automatic go_idle();
        abort = 1; tick(); abort = 0; tick();
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0;
        set_cfg(0, 0, 0, 0);
        model_reset();
        tick(); tick();
        check("rst_fre_k", fre_k, IDLE_V);
        check("rst_busy", 32'(busy), 0);
        check("rst_upd", 32'(fre_upd | done | cfg_err), 0);
        rst_n = 1;
        tick();

        // Basic sweep 1000..1030 step 10 dwell 4
        set_cfg(1000, 1030, 10, 4);
        start = 1; tick(); start = 0;
        check("t1_w0", fre_k, 1000);
        check("t1_upd0", 32'(fre_upd), 1);
        check("t1_busy", 32'(busy), 1);
        set_cfg(7, 5, 0, 1);
        repeat (4) tick();
        check("t1_w1", fre_k, 1010);
        check("t1_upd1", 32'(fre_upd), 1);
        repeat (4) tick();
        check("t1_w2", fre_k, 1020);
        repeat (4) tick();
        check("t1_w3", fre_k, 1030);
        repeat (3) tick();
        check("t1_busy16", 32'(busy), 1);
        tick();
        check("t1_done", 32'(done), 1);
`ifdef SWEEP_LOOP_EN
        check("t1_loop_busy", 32'(busy), 1);
        tick();
        check("t1_loop_w0", fre_k, 1000);
        check("t1_loop_upd", 32'(fre_upd), 1);
        go_idle();
        check("t1_loop_abort", fre_k, IDLE_V);
`else
        check("t1_busy_fall", 32'(busy), 0);
        set_cfg(500, 500, 1, 2);
        start = 1; tick();
        check("t1_start_in_done_ignored", 32'(busy), 0);
        tick(); start = 0;
        check("t1_restart_w", fre_k, 500);
        check("t1_restart_busy", 32'(busy), 1);
        repeat (4) tick();
        go_idle();
`endif

        // Clamped final step, plus an ignored start mid-run
        set_cfg(1000, 1025, 10, 4);
        start = 1; tick(); start = 0;
        repeat (5) tick();
        set_cfg(1, 9, 1, 1);
        start = 1; tick(); start = 0;
        repeat (6) tick();
        check("t2_clamp", fre_k, 1025);
        repeat (4) tick();
        check("t2_done", 32'(done), 1);
        go_idle();

        // Rejected configurations
        set_cfg(1000, 1030, 0, 4);
        start = 1; tick(); start = 0;
        check("t3_err_step0", 32'(cfg_err), 1);
        check("t3_busy", 32'(busy), 0);
        check("t3_fre", fre_k, IDLE_V);
        tick();
        check("t3_err_pulse", 32'(cfg_err), 0);
        set_cfg(2000, 1000, 10, 4);
        start = 1; tick(); start = 0;
        check("t3_err_order", 32'(cfg_err), 1);
        check("t3_fre2", fre_k, IDLE_V);
        repeat (3) tick();

        // Carry out of the word clamps to stop, dwell 0 behaves as 1
        set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0);
        start = 1; tick(); start = 0;
        check("t4_w0", fre_k, 32'hFFFF_FFF0);
        tick();
        check("t4_w1", fre_k, 32'hFFFF_FFFF);
        tick();
        check("t4_done", 32'(done), 1);
        repeat (2) tick();
        go_idle();

        // Abort during the 1010 dwell
        set_cfg(1000, 1030, 10, 4);
        start = 1; tick(); start = 0;
        repeat (6) tick();
        abort = 1; tick(); abort = 0;
        check("t5_abort_fre", fre_k, IDLE_V);
        check("t5_abort_busy", 32'(busy), 0);
        check("t5_abort_upd", 32'(fre_upd), 1);
        repeat (20) tick();

        // Simultaneous start and abort in IDLE
        start = 1; abort = 1; tick(); start = 0; abort = 0;
        check("t5_sim_busy", 32'(busy), 0);
        check("t5_sim_upd", 32'(fre_upd), 0);
        repeat (3) tick();
        check("t5_sim_busy_later", 32'(busy), 0);

        // Abort coinciding with a dwell expiry
        start = 1; tick(); start = 0;
        repeat (3) tick();
        abort = 1; tick(); abort = 0;
        check("t6_abort_expiry", fre_k, IDLE_V);
        repeat (3) tick();

        // Asynchronous reset mid-sweep
        start = 1; tick(); start = 0;
        repeat (2) tick();
        #2 rst_n = 0;
        model_reset();
        #1;
        check("t7_async_fre", fre_k, IDLE_V);
        check("t7_async_busy", 32'(busy), 0);
        tick();
        rst_n = 1;
        repeat (3) tick();
        check("t7_after_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
